// File: rtl/audio_pkg.sv
// Shared audio-path definitions: ADC widths, scheduler state
// encoding, filter designators and a mux-index helper.
package audio_pkg;

    localparam int ADC_N    = 10;
    localparam int ADC_CH_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_t;

    typedef enum logic {
        FILT_LPF = 1'b0,
        FILT_HPF = 1'b1
    } filt_sel_t;

    // ADC mux index for an offset from a base channel,
    // truncated to the mux select width.
    function automatic logic [ADC_CH_W-1:0] ch_sel(
        input int base,
        input int off
    );
        int s;
        s = base + off;
        return s[ADC_CH_W-1:0];
    endfunction

endpackage

// File: rtl/adc_conv_scheduler.sv
// Shares one ADC between audio and round-robin control channels.
// Ports: clk/reset; enable; conv_start/conv_ch/conv_busy/conv_done/
// conv_data (ADC side); audio_sample/valid, ctrl_val/valid; timeout_err.
module adc_conv_scheduler
    import audio_pkg::*;
#(
    parameter int N         = ADC_N,
    parameter int CHANNELS  = 2,
    parameter int AUDIO_CH  = 0,
    parameter int CTRL_BASE = 1,
    parameter int CTRL_DIV  = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  conv_start,
    output logic [ADC_CH_W-1:0]   conv_ch,
    input  logic                  conv_busy,
    input  logic                  conv_done,
    input  logic [N-1:0]          conv_data,
    output logic [N-1:0]          audio_sample,
    output logic                  audio_valid,
    output logic [CHANNELS*N-1:0] ctrl_val,
    output logic [CHANNELS-1:0]   ctrl_valid,
    output logic                  timeout_err
);

    localparam int ACNT_W = $clog2(CTRL_DIV + 1);
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RR_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [ACNT_W-1:0] ACNT_MAX = ACNT_W'(CTRL_DIV);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT - 1);
    localparam logic [RR_W-1:0]   RR_LAST  = RR_W'(CHANNELS - 1);

    sched_state_t      state;
    logic [ACNT_W-1:0] acnt;
    logic [TCNT_W-1:0] tcnt;
    logic [RR_W-1:0]   rr;
    logic              cur_ctrl;
    logic [RR_W-1:0]   cur_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            acnt         <= '0;
            tcnt         <= '0;
            rr           <= '0;
            cur_ctrl     <= 1'b0;
            cur_idx      <= '0;
            conv_start   <= 1'b0;
            conv_ch      <= '0;
            audio_sample <= '0;
            audio_valid  <= 1'b0;
            ctrl_val     <= '0;
            ctrl_valid   <= '0;
            timeout_err  <= 1'b0;
        end else begin
            conv_start  <= 1'b0;
            audio_valid <= 1'b0;
            ctrl_valid  <= '0;
            unique case (state)
                IDLE: begin
                    // Selection is only consumed when an issue happens,
                    // so a busy ADC simply defers it.
                    if (enable && !conv_busy) begin
                        if (acnt == ACNT_MAX) begin
                            cur_ctrl <= 1'b1;
                            cur_idx  <= rr;
                            conv_ch  <= ch_sel(CTRL_BASE, int'(rr));
                            acnt     <= '0;
                            rr       <= (rr == RR_LAST) ? '0 : rr + 1'b1;
                        end else begin
                            cur_ctrl <= 1'b0;
                            conv_ch  <= ch_sel(AUDIO_CH, 0);
                            acnt     <= acnt + 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // conv_start is seen in the first WAIT cycle, which
                    // is where the timeout count starts from zero.
                    conv_start <= 1'b1;
                    tcnt       <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (conv_done) begin
                        if (cur_ctrl) begin
                            ctrl_val[cur_idx*N +: N] <= conv_data;
                            ctrl_valid[cur_idx]      <= 1'b1;
                        end else begin
                            audio_sample <= conv_data;
                            audio_valid  <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (tcnt == TCNT_MAX) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Randomized self-checking bench for adc_conv_scheduler with a
// slot-arithmetic reference model of the channel schedule.
module tb_adc_conv_scheduler;
    import audio_pkg::*;

    localparam int N         = 10;
    localparam int CHANNELS  = 2;
    localparam int AUDIO_CH  = 0;
    localparam int CTRL_BASE = 1;
    localparam int CTRL_DIV  = 2;
    localparam int TIMEOUT   = 64;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic                  conv_start;
    logic [ADC_CH_W-1:0]   conv_ch;
    logic                  conv_busy;
    logic                  conv_done;
    logic [N-1:0]          conv_data;
    logic [N-1:0]          audio_sample;
    logic                  audio_valid;
    logic [CHANNELS*N-1:0] ctrl_val;
    logic [CHANNELS-1:0]   ctrl_valid;
    logic                  timeout_err;

    adc_conv_scheduler #(
        .N(N), .CHANNELS(CHANNELS), .AUDIO_CH(AUDIO_CH),
        .CTRL_BASE(CTRL_BASE), .CTRL_DIV(CTRL_DIV), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .conv_start(conv_start), .conv_ch(conv_ch),
        .conv_busy(conv_busy), .conv_done(conv_done),
        .conv_data(conv_data), .audio_sample(audio_sample),
        .audio_valid(audio_valid), .ctrl_val(ctrl_val),
        .ctrl_valid(ctrl_valid), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: slot k of each (CTRL_DIV+1)-slot frame is a
    // control slot when it is the last one; control slots rotate.
    int slot;
    int pend_k;
    int exp_audio;
    int exp_ctrl [CHANNELS];

    function automatic bit slot_is_ctrl(int k);
        return (k % (CTRL_DIV + 1)) == CTRL_DIV;
    endfunction

    function automatic int slot_idx(int k);
        return (k / (CTRL_DIV + 1)) % CHANNELS;
    endfunction

    function automatic int slot_ch(int k);
        return slot_is_ctrl(k) ? (CTRL_BASE + slot_idx(k)) % 8 : AUDIO_CH;
    endfunction

    function automatic logic [CHANNELS*N-1:0] ctrl_vec();
        logic [CHANNELS*N-1:0] v;
        v = '0;
        for (int c = 0; c < CHANNELS; c++) v[c*N +: N] = N'(exp_ctrl[c]);
        return v;
    endfunction

    task automatic model_reset();
        slot = 0;
        exp_audio = 0;
        for (int c = 0; c < CHANNELS; c++) exp_ctrl[c] = 0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (conv_start) ok = 1;
        end
        if (!ok) chk("start_timeout", 64'(0), 64'(1));
    endtask

    task automatic see_issue();
        chk("conv_ch", 64'(conv_ch), 64'(slot_ch(slot)));
        pend_k = slot;
        slot++;
    endtask

    // Answer the pending request dly cycles after conv_start and check
    // the capture one cycle after conv_done.
    task automatic respond(input int dly, input int data, input bit busy_after);
        int k;
        bit held;
        k = pend_k;
        held = 1;
        repeat (dly) begin
            @(negedge clk);
            if (conv_ch !== ADC_CH_W'(slot_ch(k))) held = 0;
        end
        chk("ch_hold", 64'(held), 64'(1));
        conv_done = 1'b1;
        conv_data = N'(data);
        if (busy_after) conv_busy = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        if (slot_is_ctrl(k)) begin
            exp_ctrl[slot_idx(k)] = data;
            chk("ctrl_valid", 64'(ctrl_valid), 64'(1 << slot_idx(k)));
            chk("audio_valid_q", 64'(audio_valid), 64'(0));
        end else begin
            exp_audio = data;
            chk("audio_valid", 64'(audio_valid), 64'(1));
            chk("ctrl_valid_q", 64'(ctrl_valid), 64'(0));
        end
        chk("audio_sample", 64'(audio_sample), 64'(exp_audio));
        chk("ctrl_val", 64'(ctrl_val), 64'(ctrl_vec()));
        @(negedge clk);
        chk("strobe_width", 64'({audio_valid, ctrl_valid}), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, 64'({conv_start, conv_ch, audio_sample, audio_valid,
                      ctrl_valid, timeout_err}), 64'(0));
        chk({tag, "_ctrl"}, 64'(ctrl_val), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit quiet;
        int s_data;
        reset = 1'b1;
        enable = 1'b0;
        conv_busy = 1'b0;
        conv_done = 1'b0;
        conv_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        enable = 1'b1;

        // Fixed schedule 0,0,1,0,0,2,0,0,1 with 10-cycle ADC latency.
        for (int i = 0; i < 9; i++) begin
            wait_start(ok);
            if (ok) begin
                see_issue();
                s_data = (i == 0) ? 32'h155 : int'($urandom_range(0, 1023));
                respond(10, s_data, 1'b0);
            end
        end

        // Random latencies and data.
        for (int i = 0; i < 20; i++) begin
            wait_start(ok);
            if (ok) begin
                see_issue();
                respond(int'($urandom_range(1, 12)),
                        int'($urandom_range(0, 1023)), 1'b0);
            end
        end

        // Unanswered request: timeout flag exactly TIMEOUT cycles later.
        wait_start(ok);
        if (ok) begin
            see_issue();
            quiet = 1;
            repeat (TIMEOUT - 1) begin
                @(negedge clk);
                if (audio_valid || ctrl_valid != 0) quiet = 0;
            end
            chk("to_before", 64'(timeout_err), 64'(0));
            @(negedge clk);
            chk("to_flag", 64'(timeout_err), 64'(1));
            chk("to_no_strobe", 64'(quiet), 64'(1));
        end
        for (int i = 0; i < 3; i++) begin
            wait_start(ok);
            if (ok) begin
                see_issue();
                respond(int'($urandom_range(2, 9)),
                        int'($urandom_range(0, 1023)), (i == 2));
            end
        end
        chk("to_sticky", 64'(timeout_err), 64'(1));

        // Busy held in IDLE, with a stray conv_done outside WAIT.
        quiet = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (conv_start) quiet = 0;
            conv_done = (i == 5);
            conv_data = N'(10'h3FF);
        end
        conv_done = 1'b0;
        chk("busy_no_start", 64'(quiet), 64'(1));
        chk("stray_audio", 64'(audio_sample), 64'(exp_audio));
        chk("stray_ctrl", 64'(ctrl_val), 64'(ctrl_vec()));
        conv_busy = 1'b0;
        @(negedge clk);
        chk("busy_rel_1", 64'(conv_start), 64'(0));
        @(negedge clk);
        chk("busy_rel_2", 64'(conv_start), 64'(1));
        see_issue();
        respond(5, int'($urandom_range(0, 1023)), 1'b0);

        // Enable dropped right after conv_start.
        wait_start(ok);
        if (ok) begin
            see_issue();
            enable = 1'b0;
            respond(8, int'($urandom_range(0, 1023)), 1'b0);
            quiet = 1;
            repeat (15) begin
                @(negedge clk);
                if (conv_start) quiet = 0;
            end
            chk("en_off_quiet", 64'(quiet), 64'(1));
            enable = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            wait_start(ok);
            if (ok) begin
                see_issue();
                respond(int'($urandom_range(1, 6)),
                        int'($urandom_range(0, 1023)), 1'b0);
            end
        end

        // Reset in WAIT, then a stray conv_done.
        wait_start(ok);
        if (ok) begin
            see_issue();
            repeat (3) @(negedge clk);
            reset = 1'b1;
            enable = 1'b0;
            @(negedge clk);
            check_all_zero("rst_wait");
            reset = 1'b0;
            model_reset();
            @(negedge clk);
            conv_done = 1'b1;
            conv_data = N'(10'h2AA);
            @(negedge clk);
            conv_done = 1'b0;
            check_all_zero("rst_stray");
            enable = 1'b1;
        end

        // conv_done on the last allowed cycle wins over the timeout.
        wait_start(ok);
        if (ok) begin
            see_issue();
            respond(TIMEOUT - 1, int'($urandom_range(0, 1023)), 1'b0);
            chk("edge_no_to", 64'(timeout_err), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
